vga_draw_arbiter: RTL
=====================

Name: vga_draw_arbiter

Overview:
- Schedules and shares the single VGA adapter plot port among up to N drawing engines (board clear, grid draw, ship/marker draw).
- Each engine uses the same start/done handshake: start is held high until done rises, then start drops, then the engine drops done.
- Game-control logic posts requests. The arbiter grants one engine at a time in round-robin order, sequences that engine's handshake, muxes its pixel stream to the VGA port, and acknowledges completion.

Parameters:
- N, 3, number of drawing-engine clients (2..8).
- TIMEOUT, 32768, maximum cycles a granted engine may take to raise done; must be >= 2.
- TW, 16, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  draw request per client; a 1-cycle pulse or a held level; sets the client's pending bit.
- ack  out  N  1-cycle pulse: that client's job completed.
- err  out  1  1-cycle pulse: granted engine timed out.
- busy  out  1  high in any state other than IDLE.
- eng_start  out  N  start to each engine; one-hot or zero.
- eng_done  in  N  done from each engine.
- eng_x  in  8*N  packed engine x; client i at bits [8i+7:8i].
- eng_y  in  7*N  packed engine y.
- eng_colour  in  3*N  packed engine colour.
- eng_plot  in  N  engine plot strobes.
- vga_x  out  8  to VGA adapter.
- vga_y  out  7  to VGA adapter.
- vga_colour  out  3  to VGA adapter.
- vga_plot  out  1  to VGA adapter.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0; last=N-1; eng_start=0; ack=0; err=0; busy=0; timeout counter=0. Outputs take these values immediately, without waiting for a clock edge.
- Pending: on each clock, pending[i] <= pending[i] | req[i], except a grant clears the granted bit in the same edge. A req arriving in that same edge for the granted client wins, so the bit stays set and the job runs again later.
- IDLE:
  - If pending != 0, select the first set bit searching last+1, last+2, ... modulo N. Register it as sel.
  - Next cycle: state=RUN, eng_start[sel]=1, counter=0.
- RUN:
  - eng_start[sel] is held 1; counter increments each cycle.
  - If eng_done[sel]=1: next state=DRAIN, eng_start=0.
  - Else if counter == TIMEOUT-1: next state=DRAIN, eng_start=0, err pulses for 1 cycle.
- DRAIN:
  - eng_start=0.
  - When eng_done[sel]=0: ack[sel] pulses for 1 cycle, last<=sel, state=IDLE.
  - If DRAIN was entered from a timeout, ack is still issued.
- Pixel mux: combinational, zero latency.
  - In RUN: vga_{x,y,colour,plot} = client sel's fields.
  - In IDLE or DRAIN: vga_plot=0 and x, y, colour = 0.
  - eng_plot from non-granted clients is ignored.
- Minimum job time: grant to ack is 3 cycles when the engine asserts done on the first RUN cycle and drops it immediately.
- Back-to-back: ack cycle is also the IDLE entry. A new grant is issued the following cycle (one IDLE cycle between jobs).
- Done from a non-granted engine is ignored.
- No preemption: requests arriving during RUN or DRAIN wait.

Test Plan:
- Single job: req=3'b001 pulse; engine 0 (blankboard model, colour 3'b000) plots 19200 pixels then raises done. Required:
  - eng_start=3'b001 from cycle 2 until the cycle after done rises.
  - vga_* tracks engine 0 during the run.
  - vga_plot=0 after done.
  - ack=3'b001 for one cycle after done falls.
  - busy falls with ack.
- Simultaneous requests: req=3'b111 in one cycle, last=2 after reset. Required:
  - grant order 0,1,2, each after the previous ack.
  - exactly three ack pulses: 001, 010, 100.
- Round-robin fairness: client 0 re-requests during its own run while client 1 is pending. Required:
  - client 1 is granted next.
  - client 0 runs third.
- Timeout: engine 1 never raises done, TIMEOUT=16. Required:
  - err pulses 16 cycles after eng_start[1] rises.
  - eng_start[1]=0.
  - ack[1] pulses once done is low.
  - arbiter returns to IDLE.
- Isolation: non-granted engine 2 drives eng_plot=1 and eng_done=1 during client 0's run. Required:
  - vga_plot follows client 0 only.
  - no ack[2].
  - client 0's job completes normally.
- Reset mid-run: assert rst_n=0 during a RUN with pending=3'b110. Required:
  - eng_start=0, busy=0, ack=0 immediately.
  - after release, no grant until a new req.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin scheduler sharing one VGA plot port among N drawing engines
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   req[N]                 per-client draw request (pulse or level), latched into pending
//   ack[N]                 1-cycle pulse when that client's job completes
//   err                    1-cycle pulse when the granted engine fails to raise done in time
//   busy                   high whenever a job is in progress (RUN or DRAIN)
//   eng_start[N]           one-hot start to the granted engine, held until its done rises
//   eng_done[N]            done from each engine
//   eng_x/y/colour/plot    packed per-engine pixel streams (client i at slice i)
//   vga_x/y/colour/plot    pixel stream of the granted engine, zero when no engine is running
module vga_draw_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 32768,
    parameter int TW      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   ack,
    output logic           err,
    output logic           busy,
    output logic [N-1:0]   eng_start,
    input  logic [N-1:0]   eng_done,
    input  logic [8*N-1:0] eng_x,
    input  logic [7*N-1:0] eng_y,
    input  logic [3*N-1:0] eng_colour,
    input  logic [N-1:0]   eng_plot,
    output logic [7:0]     vga_x,
    output logic [6:0]     vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [N-1:0]  pending;
    logic [SW-1:0] last, sel, pick, idx;
    logic [TW-1:0] cnt;
    logic          found, grant, ack_n, err_n, run;
    // Search starts just after the last served client so every requester gets a turn.
    always_comb begin
        pick  = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(last) + k) % N);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_n = RUN;
                    grant   = 1'b1;
                end
            end
            RUN: begin
                if (eng_done[sel]) begin
                    state_n = DRAIN;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    state_n = DRAIN;
                    err_n   = 1'b1;
                end
            end
            DRAIN: begin
                // Completion waits for the engine to drop done, even after a timeout.
                if (!eng_done[sel]) begin
                    state_n = IDLE;
                    ack_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            last    <= SW'(N - 1);
            sel     <= '0;
            cnt     <= '0;
            ack     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            // A request landing on the grant edge re-arms the bit so the job runs again later.
            pending <= (pending & ~(grant ? N'(1) << pick : '0)) | req;
            sel     <= grant ? pick : sel;
            last    <= ack_n ? sel : last;
            cnt     <= grant ? '0 : (state == RUN ? cnt + 1'b1 : cnt);
            ack     <= ack_n ? N'(1) << sel : '0;
            err     <= err_n;
        end
    end
    assign run        = (state == RUN);
    assign busy       = (state != IDLE);
    assign eng_start  = run ? N'(1) << sel : '0;
    assign vga_x      = run ? 8'(eng_x >> (8 * sel)) : 8'd0;
    assign vga_y      = run ? 7'(eng_y >> (7 * sel)) : 7'd0;
    assign vga_colour = run ? 3'(eng_colour >> (3 * sel)) : 3'd0;
    assign vga_plot   = run & eng_plot[sel];
endmodule
